// File: rtl/port_channel_bank.sv
// Bank of CH visible output ports fed from shadow registers, with an atomic commit and registered readback.
// Optional macro PORT_BANK_PARITY_EN adds per-channel even parity outputs (ch_par) updated with each commit.
module port_channel_bank #(
  parameter int WIDTH = 8,
  parameter int CH = 4,
  localparam int IDXW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [IDXW-1:0]       wr_idx,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  commit_req,
  output logic                  commit_ack,
  input  logic [IDXW-1:0]       rd_idx,
  input  logic                  rd_shadow,
  output logic [WIDTH-1:0]      rd_data,
  output logic [CH*WIDTH-1:0]   ch_out,
  output logic [CH-1:0]         dirty,
`ifdef PORT_BANK_PARITY_EN
  output logic [CH-1:0]         ch_par,
`endif
  output logic                  idx_err,
  input  logic                  err_clr
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] COMMIT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] shadow [CH];
  logic             wr_fire;
  logic             wr_hit;
  logic             rd_hit;
  logic [WIDTH-1:0] rd_sel;

`ifdef PORT_BANK_PARITY_EN
  function automatic logic parity_even(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction
`endif

  assign wr_ready = (state == IDLE);
  assign wr_fire  = wr_valid & wr_ready;

  // Index decode by match so an out-of-range index simply hits nothing
  always_comb begin
    wr_hit = 1'b0;
    rd_hit = 1'b0;
    rd_sel = '0;
    for (int k = 0; k < CH; k++) begin
      if (wr_idx == IDXW'(k)) wr_hit = 1'b1;
      if (rd_idx == IDXW'(k)) begin
        rd_hit = 1'b1;
        rd_sel = rd_shadow ? shadow[k] : ch_out[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (commit_req) state <= COMMIT;
        COMMIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Shadow writes only fire in IDLE, so they never collide with the dirty clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CH; k++) shadow[k] <= '0;
      dirty <= '0;
    end else begin
      if (state == COMMIT) dirty <= '0;
      for (int k = 0; k < CH; k++) begin
        if (wr_fire && (wr_idx == IDXW'(k))) begin
          shadow[k] <= wr_data;
          dirty[k]  <= 1'b1;
        end
      end
    end
  end

  // Visible ports move only on the COMMIT edge, all channels at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_out     <= '0;
      commit_ack <= 1'b0;
`ifdef PORT_BANK_PARITY_EN
      ch_par     <= '0;
`endif
    end else begin
      commit_ack <= (state == COMMIT);
      if (state == COMMIT) begin
        for (int k = 0; k < CH; k++) begin
          ch_out[k*WIDTH +: WIDTH] <= shadow[k];
`ifdef PORT_BANK_PARITY_EN
          ch_par[k] <= parity_even(shadow[k]);
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_sel;
    end
  end

  // Setting wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_err <= 1'b0;
    end else if ((wr_fire && !wr_hit) || !rd_hit) begin
      idx_err <= 1'b1;
    end else if (err_clr) begin
      idx_err <= 1'b0;
    end
  end

endmodule
